// File: rtl/tetris_input_pkg.sv
// Shared action indices, HID keycodes and FSM state encoding for the Tetris keyboard front end.
package tetris_input_pkg;

    typedef enum logic [2:0] {
        LEFT      = 3'd0,
        RIGHT     = 3'd1,
        SOFT_DROP = 3'd2,
        ROT_CW    = 3'd3,
        ROT_CCW   = 3'd4,
        HARD_DROP = 3'd5,
        PAUSE     = 3'd6
    } action_e;

    typedef enum logic [1:0] {
        IDLE,
        DAS,
        REPEAT
    } fsm_state_e;

    // USB HID usage codes, indexed by action_e
    localparam logic [7:0] KEY_CODE [0:6] = '{8'h50, 8'h4F, 8'h51, 8'h52, 8'h1D, 8'h2C, 8'h13};

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned das, input int unsigned arr);
        return $clog2(max_u(das, arr) + 1);
    endfunction

endpackage

// File: rtl/key_repeat_fsm.sv
// Per-action press / delayed-auto-shift / auto-repeat sequencer, advancing once per frame tick.
module key_repeat_fsm
    import tetris_input_pkg::*;
#(
    parameter int unsigned DAS_DELAY  = 10,
    parameter int unsigned ARR_PERIOD = 2,
    parameter bit          REPEATABLE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pressed,
    output logic pulse
);

    localparam int unsigned CW = cnt_width(DAS_DELAY, ARR_PERIOD);
    localparam logic [CW-1:0] CNT_MAX  = CW'(max_u(DAS_DELAY, ARR_PERIOD));
    localparam logic [CW-1:0] DAS_LAST = CW'(DAS_DELAY - 1);
    localparam logic [CW-1:0] ARR_LAST = CW'(ARR_PERIOD - 1);

    fsm_state_e    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (pressed) begin
                            pulse <= 1'b1;
                            state <= DAS;
                            cnt   <= '0;
                        end
                    end
                    DAS: begin
                        if (!pressed) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (REPEATABLE) begin
                            if (cnt == DAS_LAST) begin
                                pulse <= 1'b1;
                                state <= REPEAT;
                                cnt   <= '0;
                            end else if (cnt != CNT_MAX) begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (!pressed) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == ARR_LAST) begin
                            pulse <= 1'b1;
                            cnt   <= '0;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Keyboard-to-game-action front end: keycode decode, vsync frame tick, per-action DAS/ARR and pause gating.
module tetris_input_ctrl
    import tetris_input_pkg::*;
#(
    parameter int unsigned            NUM_KEYS    = 4,
    parameter int unsigned            NUM_ACTIONS = 7,
    parameter int unsigned            DAS_DELAY   = 10,
    parameter int unsigned            ARR_PERIOD  = 2,
    parameter logic [NUM_ACTIONS-1:0] REPEAT_MASK = 7'b0000111
) (
    input  logic                     Clk,
    input  logic                     reset_rtl_0,
    input  logic [8*NUM_KEYS-1:0]    keycodes,
    input  logic                     vsync,
    output logic [NUM_ACTIONS-1:0]   action_pulse,
    output logic [NUM_ACTIONS-1:0]   action_held,
    output logic                     pause,
    output logic                     frame_tick
);

    localparam logic [NUM_ACTIONS-1:0] PAUSE_BIT = NUM_ACTIONS'(1) << int'(PAUSE);

    logic                   vs_meta;
    logic                   vs_sync;
    logic                   vs_prev;
    logic [NUM_ACTIONS-1:0] raw;
    logic [NUM_ACTIONS-1:0] eff;
    logic [NUM_ACTIONS-1:0] fsm_pulse;

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            vs_meta    <= 1'b0;
            vs_sync    <= 1'b0;
            vs_prev    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_meta    <= vsync;
            vs_sync    <= vs_meta;
            vs_prev    <= vs_sync;
            frame_tick <= vs_sync & ~vs_prev;
        end
    end

    always_comb begin
        raw = '0;
        for (int unsigned a = 0; a < NUM_ACTIONS; a++) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (keycodes[8*k +: 8] == KEY_CODE[a]) begin
                    raw[a] = 1'b1;
                end
            end
        end
    end

    // Opposing directions cancel: both are seen as released while held together
    always_comb begin
        eff               = raw;
        eff[int'(LEFT)]   = raw[int'(LEFT)]   & ~raw[int'(RIGHT)];
        eff[int'(RIGHT)]  = raw[int'(RIGHT)]  & ~raw[int'(LEFT)];
        eff[int'(ROT_CW)] = raw[int'(ROT_CW)] & ~raw[int'(ROT_CCW)];
        eff[int'(ROT_CCW)] = raw[int'(ROT_CCW)] & ~raw[int'(ROT_CW)];
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            action_held <= '0;
        end else if (frame_tick) begin
            action_held <= eff;
        end
    end

    for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_act
        localparam bit RPT = REPEAT_MASK[a] && (a != int'(HARD_DROP)) && (a != int'(PAUSE));

        key_repeat_fsm #(
            .DAS_DELAY (DAS_DELAY),
            .ARR_PERIOD(ARR_PERIOD),
            .REPEATABLE(RPT)
        ) u_fsm (
            .clk    (Clk),
            .rst_n  (reset_rtl_0),
            .tick   (frame_tick),
            .pressed(eff[a]),
            .pulse  (fsm_pulse[a])
        );
    end

    always_ff @(posedge Clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            pause <= 1'b0;
        end else if (fsm_pulse[int'(PAUSE)]) begin
            pause <= ~pause;
        end
    end

    // While paused only the pause action itself reaches the game; other FSMs keep running
    always_comb begin
        action_pulse = pause ? (fsm_pulse & PAUSE_BIT) : fsm_pulse;
    end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Frame-level self-checking bench: table of per-frame keycodes and expected pulse/held/pause, scoreboard checked per tick.
module tb_tetris_input_ctrl;
    import tetris_input_pkg::*;

    logic        Clk = 1'b0;
    logic        reset_rtl_0;
    logic [31:0] keycodes;
    logic        vsync;
    logic [6:0]  action_pulse;
    logic [6:0]  action_held;
    logic        pause;
    logic        frame_tick;

    always #5 Clk = ~Clk;

    tetris_input_ctrl #(
        .NUM_KEYS   (4),
        .NUM_ACTIONS(7),
        .DAS_DELAY  (10),
        .ARR_PERIOD (2),
        .REPEAT_MASK(7'b0000111)
    ) dut (
        .Clk         (Clk),
        .reset_rtl_0 (reset_rtl_0),
        .keycodes    (keycodes),
        .vsync       (vsync),
        .action_pulse(action_pulse),
        .action_held (action_held),
        .pause       (pause),
        .frame_tick  (frame_tick)
    );

    typedef struct {
        logic [31:0] keys;
        logic [6:0]  pulse;
        logic [6:0]  held;
        logic        pause_e;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [31:0] k, input logic [6:0] p, input logic [6:0] h, input logic ps);
        vec_t v;
        v.keys = k; v.pulse = p; v.held = h; v.pause_e = ps;
        vecs.push_back(v);
    endfunction

    function automatic vec_t mk(input logic [31:0] k, input logic [6:0] p, input logic [6:0] h, input logic ps);
        vec_t v;
        v.keys = k; v.pulse = p; v.held = h; v.pause_e = ps;
        return v;
    endfunction

    // Monitor: pulse and held one cycle after the tick, pulse gone and pause settled a cycle later
    logic [6:0] m_p1, m_h1, m_p2;
    logic       m_ps;
    vec_t       m_e;
    initial begin : monitor
        forever begin
            @(negedge Clk);
            if (frame_tick === 1'b1) begin
                @(negedge Clk);
                m_p1 = action_pulse;
                m_h1 = action_held;
                @(negedge Clk);
                m_p2 = action_pulse;
                m_ps = pause;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tick: got a frame_tick expected none");
                end else begin
                    m_e = sb.pop_front();
                    check("action_pulse", {25'b0, m_p1}, {25'b0, m_e.pulse});
                    check("action_held", {25'b0, m_h1}, {25'b0, m_e.held});
                    check("pulse_width", {25'b0, m_p2}, 32'h0);
                    check("pause", {31'b0, m_ps}, {31'b0, m_e.pause_e});
                end
            end
        end
    end

    task automatic do_frame(input vec_t v, input bit chk_lat, input bit glitch);
        if (glitch) begin
            keycodes = 32'h0000_0050;
            repeat (3) @(posedge Clk);
        end
        keycodes = v.keys;
        sb.push_back(v);
        @(posedge Clk);
        #3 vsync = 1'b1;
        if (chk_lat) begin
            for (int i = 1; i <= 6; i++) begin
                @(posedge Clk);
                #1 check($sformatf("tick_latency_%0d", i), {31'b0, frame_tick}, {31'b0, (i == 3)});
            end
        end else begin
            repeat (6) @(posedge Clk);
        end
        #2 vsync = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge Clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge Clk);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // DAS/ARR on slot 2
        for (int f = 0; f < 20; f++)
            add(32'h0050_0000, (f == 0 || (f >= 10 && f % 2 == 0)) ? 7'h01 : 7'h00, 7'h01, 1'b0);
        add(32'h0, 7'h00, 7'h00, 1'b0);
        // Non-repeatable hard drop
        for (int f = 0; f < 30; f++)
            add(32'h0000_002C, (f == 0) ? 7'h20 : 7'h00, 7'h20, 1'b0);
        add(32'h0, 7'h00, 7'h00, 1'b0);
        // Left/right conflict, then right dropped
        for (int f = 0; f < 3; f++) add(32'h4F00_0050, 7'h00, 7'h00, 1'b0);
        add(32'h0000_0050, 7'h01, 7'h01, 1'b0);
        add(32'h0, 7'h00, 7'h00, 1'b0);
        // Pause, masked rotate, unpause while rotate still tracked
        add(32'h0000_1300, 7'h40, 7'h40, 1'b1);
        add(32'h0, 7'h00, 7'h00, 1'b1);
        add(32'h0000_0052, 7'h00, 7'h08, 1'b1);
        add(32'h0000_0052, 7'h00, 7'h08, 1'b1);
        add(32'h0000_1352, 7'h40, 7'h48, 1'b0);
        add(32'h0, 7'h00, 7'h00, 1'b0);
        // Duplicate codes in every slot vs a single slot
        for (int f = 0; f < 14; f++)
            add(32'h5151_5151, (f == 0 || f == 10 || f == 12) ? 7'h04 : 7'h00, 7'h04, 1'b0);
        add(32'h0, 7'h00, 7'h00, 1'b0);
        for (int f = 0; f < 14; f++)
            add(32'h0000_5100, (f == 0 || f == 10 || f == 12) ? 7'h04 : 7'h00, 7'h04, 1'b0);
        add(32'h0, 7'h00, 7'h00, 1'b0);
        // Release and re-press in consecutive frames
        add(32'h0000_0050, 7'h01, 7'h01, 1'b0);
        add(32'h0, 7'h00, 7'h00, 1'b0);
        add(32'h0000_0050, 7'h01, 7'h01, 1'b0);
        add(32'h0, 7'h00, 7'h00, 1'b0);

        reset_rtl_0 = 1'b0;
        vsync       = 1'b0;
        keycodes    = 32'h0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_pulse", {25'b0, action_pulse}, 32'h0);
        check("reset_held", {25'b0, action_held}, 32'h0);
        check("reset_pause", {31'b0, pause}, 32'h0);
        check("reset_tick", {31'b0, frame_tick}, 32'h0);
        @(negedge Clk);
        reset_rtl_0 = 1'b1;
        repeat (2) @(posedge Clk);

        do_frame(mk(32'h0, 7'h00, 7'h00, 1'b0), 1'b1, 1'b0);
        for (int i = 0; i < vecs.size(); i++) do_frame(vecs[i], 1'b0, 1'b0);

        // A keycode present only between ticks is never seen
        do_frame(mk(32'h0, 7'h00, 7'h00, 1'b0), 1'b0, 1'b1);

        // Reset while holding left, then a fresh press after release
        for (int f = 0; f < 5; f++)
            do_frame(mk(32'h0000_0050, (f == 0) ? 7'h01 : 7'h00, 7'h01, 1'b0), 1'b0, 1'b0);
        @(negedge Clk);
        #2 reset_rtl_0 = 1'b0;
        #1;
        check("midreset_held", {25'b0, action_held}, 32'h0);
        check("midreset_pulse", {25'b0, action_pulse}, 32'h0);
        check("midreset_pause", {31'b0, pause}, 32'h0);
        check("midreset_tick", {31'b0, frame_tick}, 32'h0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        reset_rtl_0 = 1'b1;
        repeat (2) @(posedge Clk);
        do_frame(mk(32'h0000_0050, 7'h01, 7'h01, 1'b0), 1'b1, 1'b0);
        do_frame(mk(32'h0, 7'h00, 7'h00, 1'b0), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
